stream_demux_1_n: RTL

Parametrised registered 1:N demultiplexer, the successor to the combinational 1:4 demux. It routes one valid/ready input stream to one of N output channels selected per beat. Each output channel has a one-entry holding register, so stalled channels apply backpressure without corrupting the other channels. Intended as the fan-out stage ahead of per-channel consumers.

---
 rtl/stream_demux_1_n.sv | 96 +++++++++
 1 files changed

// File: rtl/stream_demux_1_n.sv
// stream_demux_1_n: registered 1:N valid/ready demultiplexer with one holding
// register per output channel; beats with an out-of-range select are dropped.
//
// Ports:
//   clk, rst            single rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake (in_ready is combinational)
//   in_sel              destination channel of the current beat
//   in_data             beat payload
//   out_valid[k]        channel k holds a beat
//   out_ready[k]        channel k consumer accepts
//   out_data            channel k payload at [k*WIDTH +: WIDTH]
//   sel_err             one-cycle pulse after a discarded out-of-range beat
//   beat_cnt            (only with STREAM_DEMUX_CNT_EN) per-channel 16-bit
//                       count of completed output transfers at [k*16 +: 16]
//
// Optional feature macro: STREAM_DEMUX_CNT_EN
module stream_demux_1_n #(
    parameter int WIDTH = 8,
    parameter int N     = 4,
    parameter int SEL_W = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   in_sel,
    input  logic [WIDTH-1:0]   in_data,
    output logic [N-1:0]       out_valid,
    input  logic [N-1:0]       out_ready,
    output logic [N*WIDTH-1:0] out_data,
    output logic               sel_err
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [N*16-1:0]    beat_cnt
`endif
);

    logic [N-1:0] hit;
    logic         sel_ok;
    logic         tgt_free;
    logic         acc;
    logic [N-1:0] load;

    // Decode the select by loop so an out-of-range in_sel never indexes
    // past the channel vector; no hit means the beat is discarded.
    always_comb begin
        hit      = '0;
        tgt_free = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (in_sel == SEL_W'(k)) begin
                hit[k]   = 1'b1;
                tgt_free = !out_valid[k] || out_ready[k];
            end
        end
    end

    assign sel_ok   = |hit;
    assign in_ready = !rst && tgt_free;
    assign acc      = in_valid && in_ready;
    assign load     = hit & {N{acc}};

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= '0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= acc && !sel_ok;
            for (int k = 0; k < N; k++) begin
                // Refill wins over drain so a channel sustains one beat
                // per cycle.
                if (load[k]) begin
                    out_data[k*WIDTH +: WIDTH] <= in_data;
                    out_valid[k]               <= 1'b1;
                end else if (out_ready[k]) begin
                    out_valid[k] <= 1'b0;
                end
            end
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt <= '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    beat_cnt[k*16 +: 16] <= beat_cnt[k*16 +: 16] + 16'd1;
                end
            end
        end
    end
`endif

endmodule
